shift_amt_seq: RTL

Parametrised sequential shift unit for the multicycle datapath. It combines shift-amount source selection with a one-bit-per-cycle shifter that supports four modes. A start/busy/done handshake lets the control FSM issue a shift and wait for completion. It generalises fixed 4-way, 5-bit amount selection to any source count and data width, and adds a registered amount and an arithmetic/rotate capability.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_amt_sel.sv | 28 ++
 rtl/shift_amt_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit: shift modes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/shift_amt_sel.sv
// Combinational NUM_SRC-way selector of AMT_W-bit amount fields; an
// out-of-range select yields zero.
module shift_amt_sel #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int AMT_W   = 5
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*AMT_W-1:0] srcs,
  output logic [AMT_W-1:0]         amt
);

  // Pad the table to the full selector range so unused codes read as zero.
  logic [AMT_W-1:0] src_arr [2**SEL_W];

  generate
    for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_src
      if (gi < NUM_SRC) begin : g_used
        assign src_arr[gi] = srcs[gi*AMT_W +: AMT_W];
      end else begin : g_unused
        assign src_arr[gi] = '0;
      end
    end
  endgenerate

  assign amt = src_arr[sel];

endmodule

// File: rtl/shift_amt_seq.sv
// Sequential shift unit: selects a shift amount, then shifts one bit per
// cycle in SLL/SRL/SRA/ROR mode, with a start/busy/done handshake.
module shift_amt_seq
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  localparam int AMT_W  = $clog2(DATA_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SEL_W-1:0]         seletor,
  input  logic [NUM_SRC*AMT_W-1:0] amt_srcs,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic [AMT_W-1:0]         amt_latched,
  output logic                     busy,
  output logic                     done
);

  shift_state_t      state_reg, state_next;
  shift_mode_t       mode_reg, mode_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [AMT_W-1:0]  amt_reg, amt_next;
  logic [AMT_W-1:0]  cnt_reg, cnt_next;
  logic [AMT_W-1:0]  sel_amt;
  logic [DATA_W-1:0] step_data;

  shift_amt_sel #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W),
    .AMT_W   (AMT_W)
  ) u_amt_sel (
    .sel  (seletor),
    .srcs (amt_srcs),
    .amt  (sel_amt)
  );

  always_comb begin
    step_data = data_reg;
    case (mode_reg)
      SH_SLL: step_data = {data_reg[DATA_W-2:0], 1'b0};
      SH_SRL: step_data = {1'b0, data_reg[DATA_W-1:1]};
      SH_SRA: step_data = {data_reg[DATA_W-1], data_reg[DATA_W-1:1]};
      SH_ROR: step_data = {data_reg[0], data_reg[DATA_W-1:1]};
      default: step_data = data_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    data_next  = data_reg;
    amt_next   = amt_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          data_next  = data_in;
          mode_next  = shift_mode_t'(mode);
          amt_next   = sel_amt;
          cnt_next   = sel_amt;
          state_next = (sel_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_next = step_data;
        cnt_next  = cnt_reg - AMT_W'(1);
        if (cnt_reg == AMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      mode_reg  <= SH_SLL;
      data_reg  <= '0;
      amt_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      data_reg  <= data_next;
      amt_reg   <= amt_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign data_out    = data_reg;
  assign amt_latched = amt_reg;
  assign busy        = (state_reg == SHIFT);
  assign done        = (state_reg == DONE);

endmodule
